// File: rtl/ac_op_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ac_seq_pkg : opcodes, control-word bits, FSM states, ctrl mapping  |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package ac_seq_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_LDA = 4'd3;
  localparam logic [3:0] OP_INP = 4'd4;
  localparam logic [3:0] OP_CMA = 4'd5;
  localparam logic [3:0] OP_CIR = 4'd6;
  localparam logic [3:0] OP_CIL = 4'd7;
  localparam logic [3:0] OP_CLE = 4'd8;
  localparam logic [3:0] OP_CME = 4'd9;

  localparam int CS_AND  = 0;
  localparam int CS_ADD  = 1;
  localparam int CS_DR   = 2;
  localparam int CS_INPR = 3;
  localparam int CS_COM  = 4;
  localparam int CS_SHR  = 5;
  localparam int CS_SHL  = 6;
  localparam int CS_LD   = 7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Ops that only touch E (or nothing) leave LD low so the AC holds.
  function automatic logic [7:0] op_ctrl_word(input logic [3:0] op);
    logic [7:0] w;
    w = 8'h00;
    case (op)
      OP_AND:  w[CS_AND]  = 1'b1;
      OP_ADD:  w[CS_ADD]  = 1'b1;
      OP_LDA:  w[CS_DR]   = 1'b1;
      OP_INP:  w[CS_INPR] = 1'b1;
      OP_CMA:  w[CS_COM]  = 1'b1;
      OP_CIR:  w[CS_SHR]  = 1'b1;
      OP_CIL:  w[CS_SHL]  = 1'b1;
      default: w = 8'h00;
    endcase
    if (w != 8'h00) w[CS_LD] = 1'b1;
    return w;
  endfunction

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_CME);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ac_op_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ac_op_sequencer_if : request handshake plus datapath control bus   |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
interface ac_op_sequencer_if #(
  parameter int CNT_W = 3
);
  logic             op_valid;
  logic             op_ready;
  logic [3:0]       op_code;
  logic [CNT_W-1:0] op_cnt;
  logic             ac_lsb;
  logic             ac_msb;
  logic             co_in;
  logic [7:0]       ctrl_sig;
  logic             e_ff;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output op_valid, op_code, op_cnt, ac_lsb, ac_msb, co_in,
    input  op_ready, ctrl_sig, e_ff, busy, done, err
  );

  modport slave (
    input  op_valid, op_code, op_cnt, ac_lsb, ac_msb, co_in,
    output op_ready, ctrl_sig, e_ff, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/ac_op_sequencer_iter_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ac_seq_iter_cnt : loadable down-counter flagging the last iteration|
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module ac_seq_iter_cnt #(
  parameter int CNT_W = 3
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load_i,
  input  wire logic [CNT_W-1:0] load_val_i,
  input  wire logic             dec_i,
  output logic                  last_o
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == CNT_W'(1));
endmodule
`default_nettype wire

// File: rtl/ac_op_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ac_op_sequencer : AC micro-op sequencer, owns E and ControlSig     |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module ac_op_sequencer
  import ac_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 3
) (
  input wire logic          clk,
  input wire logic          rst_n,
  ac_op_sequencer_if.slave  bus
);
  if (N < 2) begin : g_bad_width
    $error("ac_op_sequencer: N must be at least 2");
  end

  logic [1:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [7:0]       ctrl_q, ctrl_d;
  logic             e_q, e_d;
  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic [CNT_W-1:0] w_iter;

  assign w_accept = (state_q == S_IDLE) && bus.op_valid;
  assign w_shift  = (bus.op_code == OP_CIR) || (bus.op_code == OP_CIL);
  // A zero shift count still performs one shift.
  assign w_iter   = (!w_shift || (bus.op_cnt == '0)) ? CNT_W'(1) : bus.op_cnt;

  ac_seq_iter_cnt #(.CNT_W(CNT_W)) u_iter_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (w_accept),
    .load_val_i (w_iter),
    .dec_i      (state_q == S_EXEC),
    .last_o     (w_last)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ctrl_d  = ctrl_q;
    e_d     = e_q;
    case (state_q)
      S_IDLE: begin
        if (bus.op_valid) begin
          state_d = S_EXEC;
          op_d    = bus.op_code;
          ctrl_d  = op_ctrl_word(bus.op_code);
        end
      end
      S_EXEC: begin
        // E samples pre-shift AC bits on the same edge the AC loads.
        case (op_q)
          OP_ADD:  e_d = bus.co_in;
          OP_CIR:  e_d = bus.ac_lsb;
          OP_CIL:  e_d = bus.ac_msb;
          OP_CLE:  e_d = 1'b0;
          OP_CME:  e_d = ~e_q;
          default: e_d = e_q;
        endcase
        if (w_last) begin
          state_d = S_DONE;
          ctrl_d  = 8'h00;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        ctrl_d  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      ctrl_q  <= 8'h00;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctrl_q  <= ctrl_d;
      e_q     <= e_d;
    end
  end

  assign bus.op_ready = (state_q == S_IDLE);
  assign bus.busy     = (state_q == S_EXEC) || (state_q == S_DONE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.err      = (state_q == S_DONE) && !op_is_legal(op_q);
  assign bus.ctrl_sig = ctrl_q;
  assign bus.e_ff     = e_q;
endmodule
`default_nettype wire

// File: tb/tb_ac_op_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ac_op_sequencer : random + directed ops against a ring model    |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module tb_ac_op_sequencer;
  localparam int N  = 4;
  localparam int CW = 3;

  typedef struct packed {
    logic [7:0] ctrl;
    logic       e;
    logic [3:0] ac;
    logic       ready;
    logic       busy;
    logic       done;
    logic       err;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ac_op_sequencer_if #(.CNT_W(CW)) bus ();
  ac_op_sequencer #(.N(N), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Simple AC datapath driven by the DUT control word.
  logic [3:0] env_ac = 4'h0;
  logic [3:0] env_dr;
  logic [3:0] env_inpr;
  logic [4:0] w_sum;
  assign w_sum      = {1'b0, env_ac} + {1'b0, env_dr};
  assign bus.ac_lsb = env_ac[0];
  assign bus.ac_msb = env_ac[3];
  assign bus.co_in  = w_sum[4];

  always @(posedge clk) begin
    if (bus.ctrl_sig[7]) begin
      if      (bus.ctrl_sig[0]) env_ac <= env_ac & env_dr;
      else if (bus.ctrl_sig[1]) env_ac <= w_sum[3:0];
      else if (bus.ctrl_sig[2]) env_ac <= env_dr;
      else if (bus.ctrl_sig[3]) env_ac <= env_inpr;
      else if (bus.ctrl_sig[4]) env_ac <= ~env_ac;
      else if (bus.ctrl_sig[5]) env_ac <= {bus.e_ff, env_ac[3:1]};
      else if (bus.ctrl_sig[6]) env_ac <= {env_ac[2:0], bus.e_ff};
    end
  end

  int   total = 0;
  int   bad = 0;
  int   shift_hits = 0;
  int   err_hits = 0;
  rec_t exp_q[$];
  rec_t last_rec;
  bit   was_idle;
  logic m_e;
  logic [3:0] m_ac;

  // One architectural step on the {E,AC} pair.
  function automatic logic [4:0] model_step(input logic [3:0] op, input logic [4:0] v,
                                            input logic [3:0] dr, input logic [3:0] inp);
    logic e;
    logic [3:0] ac;
    e  = v[4];
    ac = v[3:0];
    case (op)
      4'd1:    return {e, ac & dr};
      4'd2:    return {1'b0, ac} + {1'b0, dr};
      4'd3:    return {e, dr};
      4'd4:    return {e, inp};
      4'd5:    return {e, ~ac};
      4'd6:    return {ac[0], e, ac[3:1]};
      4'd7:    return {ac[3], ac[2:0], e};
      4'd8:    return {1'b0, ac};
      4'd9:    return {~e, ac};
      default: return v;
    endcase
  endfunction

  function automatic logic [7:0] exp_word(input logic [3:0] op);
    case (op)
      4'd1:    return 8'h81;
      4'd2:    return 8'h82;
      4'd3:    return 8'h84;
      4'd4:    return 8'h88;
      4'd5:    return 8'h90;
      4'd6:    return 8'hA0;
      4'd7:    return 8'hC0;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    rec_t r;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      was_idle = 1'b0;
    end else begin
      r = '{ctrl: 8'h00, e: m_e, ac: m_ac, ready: 1'b1, busy: 1'b0, done: 1'b0, err: 1'b0};
      was_idle = 1'b1;
    end
    last_rec = r;
    chk("ctrl_sig", bus.ctrl_sig, r.ctrl);
    chk("e_ff", 8'(bus.e_ff), 8'(r.e));
    chk("ac", 8'(env_ac), 8'(r.ac));
    chk("op_ready", 8'(bus.op_ready), 8'(r.ready));
    chk("busy", 8'(bus.busy), 8'(r.busy));
    chk("done", 8'(bus.done), 8'(r.done));
    chk("err", 8'(bus.err), 8'(r.err));
    if (bus.ctrl_sig == 8'hA0 || bus.ctrl_sig == 8'hC0) shift_hits++;
    if (bus.err) err_hits++;
    if (!was_idle) begin
      bus.op_valid = 1'($urandom_range(0, 1));
      bus.op_code  = 4'($urandom);
      bus.op_cnt   = 3'($urandom);
    end else begin
      bus.op_valid = 1'b0;
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] cnt,
                       input logic [3:0] dr, input logic [3:0] inp);
    int k;
    logic [4:0] v;
    logic [7:0] w;
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.op_cnt   = cnt;
    env_dr       = dr;
    env_inpr     = inp;
    k = (op == 4'd6 || op == 4'd7) ? ((cnt == 3'd0) ? 1 : int'(cnt)) : 1;
    v = {m_e, m_ac};
    w = exp_word(op);
    for (int i = 0; i < k; i++) begin
      exp_q.push_back('{ctrl: w, e: v[4], ac: v[3:0], ready: 1'b0, busy: 1'b1,
                        done: 1'b0, err: 1'b0});
      v = model_step(op, v, dr, inp);
    end
    exp_q.push_back('{ctrl: 8'h00, e: v[4], ac: v[3:0], ready: 1'b0, busy: 1'b1,
                      done: 1'b1, err: (op > 4'd9)});
    m_e  = v[4];
    m_ac = v[3:0];
  endtask

  task automatic run_op(input logic [3:0] op, input logic [2:0] cnt,
                        input logic [3:0] dr, input logic [3:0] inp);
    int guard;
    guard = 0;
    while (!was_idle && guard < 40) begin
      tick();
      guard++;
    end
    if (!was_idle) begin
      total++;
      bad++;
      $display("FAIL idle_wait: actual=not_idle required=idle");
      return;
    end
    issue(op, cnt, dr, inp);
    tick();
    guard = 0;
    while (!was_idle && guard < 40) begin
      tick();
      guard++;
    end
    if (!was_idle) begin
      total++;
      bad++;
      $display("FAIL op_complete: actual=stuck required=idle op=%0d", op);
    end
  endtask

  initial begin
    logic [3:0] save_ac;
    logic       save_e;
    bus.op_valid = 1'b0;
    bus.op_code  = 4'd0;
    bus.op_cnt   = 3'd0;
    env_dr       = 4'd0;
    env_inpr     = 4'd0;
    m_e          = 1'b0;
    m_ac         = 4'd0;
    was_idle     = 1'b0;
    rst_n        = 1'b1;
    #2 rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", bus.ctrl_sig, 8'h00);
    chk("rst_ready", 8'(bus.op_ready), 8'h01);
    chk("rst_done", 8'(bus.done), 8'h00);
    chk("rst_e", 8'(bus.e_ff), 8'h00);
    rst_n = 1'b1;
    tick();

    // ADD with carry out of F+1
    run_op(4'd3, 3'd0, 4'hF, 4'h0);
    run_op(4'd2, 3'd0, 4'h1, 4'h0);
    chk("add_ac", 8'(env_ac), 8'h00);
    chk("add_e", 8'(bus.e_ff), 8'h01);

    // CIR by 2 through the 5-bit ring
    run_op(4'd8, 3'd0, 4'h0, 4'h0);
    run_op(4'd3, 3'd0, 4'b0011, 4'h0);
    shift_hits = 0;
    run_op(4'd6, 3'd2, 4'h0, 4'h0);
    chk("cir2_cycles", 8'(shift_hits), 8'd2);
    chk("cir2_e", 8'(bus.e_ff), 8'h01);
    chk("cir2_ac", 8'(env_ac), 8'h08);

    shift_hits = 0;
    run_op(4'd7, 3'd0, 4'h0, 4'h0);
    chk("cil0_cycles", 8'(shift_hits), 8'd1);

    run_op(4'd8, 3'd0, 4'h0, 4'h0);
    run_op(4'd9, 3'd0, 4'h0, 4'h0);
    chk("cme1_e", 8'(bus.e_ff), 8'h01);
    run_op(4'd9, 3'd0, 4'h0, 4'h0);
    chk("cme2_e", 8'(bus.e_ff), 8'h00);

    save_ac  = env_ac;
    save_e   = bus.e_ff;
    err_hits = 0;
    run_op(4'hC, 3'd3, 4'h5, 4'h6);
    chk("illegal_err_pulses", 8'(err_hits), 8'd1);
    chk("illegal_ac", 8'(env_ac), 8'(save_ac));
    chk("illegal_e", 8'(bus.e_ff), 8'(save_e));

    // Reset in the middle of a long CIR with E=1
    run_op(4'd3, 3'd0, 4'hF, 4'h0);
    run_op(4'd9, 3'd0, 4'h0, 4'h0);
    issue(4'd6, 3'd5, 4'h0, 4'h0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", bus.ctrl_sig, 8'h00);
    chk("midrst_e", 8'(bus.e_ff), 8'h00);
    chk("midrst_ready", 8'(bus.op_ready), 8'h01);
    chk("midrst_busy", 8'(bus.busy), 8'h00);
    m_ac = last_rec.ac;
    m_e  = 1'b0;
    exp_q.delete();
    bus.op_valid = 1'b0;
    @(negedge clk);
    chk("midrst_done", 8'(bus.done), 8'h00);
    rst_n    = 1'b1;
    was_idle = 1'b1;

    repeat (250) begin
      repeat ($urandom_range(0, 2)) tick();
      run_op(4'($urandom_range(0, 15)), 3'($urandom), 4'($urandom), 4'($urandom));
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
